// File: rtl/serializer_piso.sv
// Parallel-in / serial-out shifter with a valid/ready load port.
// Words go out MSB first, one bit per clock, with no gap between
// back-to-back words. done marks the final bit (bit 0) of each word.
module serializer_piso #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load_valid,
   input  logic [WIDTH-1:0] data_in,
   output logic             load_ready,
   output logic             sout,
   output logic             sout_valid,
   output logic             done,
   output logic             busy
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic {IDLE, SHIFT} state_t;

   state_t           state, state_nxt;
   logic [WIDTH-1:0] shreg, shreg_nxt;
   logic [CW-1:0]    cnt, cnt_nxt;
   logic             last_bit;
   logic             accept;

   // State register; reset wins over any acceptance on the same edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         shreg <= '0;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         shreg <= shreg_nxt;
         cnt   <= cnt_nxt;
      end
   end

   // Outputs and next state; the last-bit cycle doubles as a load slot
   // so a new word can follow with zero bubble.
   always_comb begin
      state_nxt  = state;
      shreg_nxt  = shreg;
      cnt_nxt    = cnt;
      last_bit   = (state == SHIFT) && (cnt == LAST);
      load_ready = (state == IDLE) || last_bit;
      accept     = load_valid && load_ready;
      busy       = (state == SHIFT);
      sout_valid = (state == SHIFT);
      sout       = (state == SHIFT) ? shreg[WIDTH-1] : 1'b0;
      done       = last_bit;

      if (accept) begin
         state_nxt = SHIFT;
         shreg_nxt = data_in;
         cnt_nxt   = '0;
      end else if (state == SHIFT) begin
         // After WIDTH shifts shreg is all zeros, so IDLE sees a clean
         // register; cnt is cleared explicitly for non-power-of-2 WIDTH.
         shreg_nxt = {shreg[WIDTH-2:0], 1'b0};
         if (last_bit) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
         end else begin
            cnt_nxt = cnt + CW'(1);
         end
      end
   end

endmodule

// File: tb/tb_serializer_piso.sv
// Scoreboard bench: stimulus pushes expected (bit, done) pairs, monitors
// on the falling edge pop and compare whenever sout_valid is high.
module tb_serializer_piso;

   typedef struct {
      logic b;
      logic d;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst, lv, rst4, lv4;
   logic [7:0] din;
   logic [3:0] din4;
   logic       lr, so, sv, dn, by;
   logic       lr4, so4, sv4, dn4, by4;

   int   n_chk  = 0;
   int   n_fail = 0;
   exp_t q8[$];
   exp_t q4[$];

   always #5 clk = ~clk;

   serializer_piso #(.WIDTH(8)) dut8 (
      .clk(clk), .rst(rst), .load_valid(lv), .data_in(din),
      .load_ready(lr), .sout(so), .sout_valid(sv), .done(dn), .busy(by)
   );

   serializer_piso #(.WIDTH(4)) dut4 (
      .clk(clk), .rst(rst4), .load_valid(lv4), .data_in(din4),
      .load_ready(lr4), .sout(so4), .sout_valid(sv4), .done(dn4), .busy(by4)
   );

   task automatic chk(input string name, input int act, input int exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Push expected bits from a hand-written MSB-first string; done on the
   // entry flagged by done_at (-1 for none).
   task automatic push(input int which, input string bits, input int done_at);
      exp_t e;
      for (int k = 0; k < bits.len(); k++) begin
         e.b = (bits[k] == "1");
         e.d = (k == done_at);
         if (which == 8) q8.push_back(e);
         else            q4.push_back(e);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // Monitor for the 8-bit instance.
   always @(negedge clk) begin
      exp_t e;
      if (sv === 1'b1) begin
         if (q8.size() == 0) begin
            chk("w8_unexpected_bit", 1, 0);
         end else begin
            e = q8.pop_front();
            chk("w8_sout", int'(so), int'(e.b));
            chk("w8_done", int'(dn), int'(e.d));
         end
      end else begin
         chk("w8_idle_done", int'(dn), 0);
         chk("w8_idle_sout", int'(so), 0);
      end
   end

   // Monitor for the 4-bit instance.
   always @(negedge clk) begin
      exp_t e;
      if (sv4 === 1'b1) begin
         if (q4.size() == 0) begin
            chk("w4_unexpected_bit", 1, 0);
         end else begin
            e = q4.pop_front();
            chk("w4_sout", int'(so4), int'(e.b));
            chk("w4_done", int'(dn4), int'(e.d));
         end
      end else begin
         chk("w4_idle_done", int'(dn4), 0);
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int bcnt;
      // Reset with a word offered: nothing may be accepted.
      rst = 1'b1; lv = 1'b1; din = 8'hA5;
      rst4 = 1'b1; lv4 = 1'b0; din4 = 4'h0;
      tick; tick;
      chk("rst_load_ready", int'(lr), 1);
      chk("rst_sout_valid", int'(sv), 0);
      chk("rst_busy", int'(by), 0);
      chk("rst_done", int'(dn), 0);
      chk("rst_sout", int'(so), 0);
      chk("rst4_busy", int'(by4), 0);
      rst = 1'b0; lv = 1'b0; rst4 = 1'b0;
      tick;
      chk("post_rst_idle_busy", int'(by), 0);

      // Single word from IDLE.
      lv = 1'b1; din = 8'hA5;
      push(8, "10100101", 7);
      tick;
      lv = 1'b0; din = 8'h00;
      for (int i = 0; i < 8; i++) begin
         chk("a5_load_ready", int'(lr), (i == 7) ? 1 : 0);
         chk("a5_busy", int'(by), 1);
         tick;
      end
      chk("a5_end_busy", int'(by), 0);
      chk("a5_end_ready", int'(lr), 1);

      // Back-to-back with load_valid held high.
      lv = 1'b1; din = 8'hF0;
      push(8, "11110000", 7);
      tick;
      for (int i = 0; i < 16; i++) begin
         chk("b2b_valid", int'(sv), 1);
         if (i == 7) begin
            din = 8'h0F;
            push(8, "00001111", 7);
         end
         if (i == 8) lv = 1'b0;
         tick;
      end
      chk("b2b_end_busy", int'(by), 0);
      chk("b2b_end_valid", int'(sv), 0);

      // Load pulse while not ready is ignored.
      lv = 1'b1; din = 8'h3C;
      push(8, "00111100", 7);
      tick;
      for (int i = 0; i < 8; i++) begin
         if (i == 3) begin lv = 1'b1; din = 8'hFF; end
         else        begin lv = 1'b0; din = 8'h00; end
         tick;
      end
      chk("ign_end_busy", int'(by), 0);

      // Reset during the 4th bit aborts the word.
      lv = 1'b1; din = 8'hC3;
      push(8, "1100", -1);
      tick;
      lv = 1'b0;
      tick; tick; tick;
      rst = 1'b1;
      tick;
      rst = 1'b0;
      chk("abort_valid", int'(sv), 0);
      chk("abort_busy", int'(by), 0);
      chk("abort_done", int'(dn), 0);
      tick;
      chk("abort_valid2", int'(sv), 0);
      lv = 1'b1; din = 8'h81;
      push(8, "10000001", 7);
      tick;
      lv = 1'b0;
      repeat (8) tick;
      chk("r81_end_busy", int'(by), 0);

      // WIDTH=4 instance.
      lv4 = 1'b1; din4 = 4'b1001;
      push(4, "1001", 3);
      tick;
      lv4 = 1'b0;
      bcnt = 0;
      for (int i = 0; i < 10; i++) begin
         if (by4) bcnt++;
         tick;
      end
      chk("w4_busy_cycles", bcnt, 4);

      tick;
      chk("q8_drained", q8.size(), 0);
      chk("q4_drained", q4.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
